// File: rtl/ddr_mem_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : ddr_mem_bridge_if
// Description : Bus bundle between the CPU data-RAM port, the DDR memory
//               bridge and the MIG DDR2 user interface (app_*).
//               master modport : the bridge (drives MIG commands, CPU
//                                stall/ack/read data)
//               slave modport  : the environment (CPU requests, MIG
//                                responses, calibration status)
// Ports       : ram_* CPU request/response, stall_o/ack_o CPU flow control,
//               init_calib_complete, app_* MIG user interface
// Revision    : 1.0 - initial release
// ============================================================================
interface ddr_mem_bridge_if #(
  parameter int APP_ADDR_W = 27,
  parameter int APP_DATA_W = 128
);
  // CPU data-RAM side
  logic                    ram_ce_i;
  logic                    ram_we_i;
  logic [31:0]             ram_addr_i;
  logic [3:0]              ram_sel_i;
  logic [31:0]             ram_data_i;
  logic [31:0]             ram_data_o;
  logic                    stall_o;
  logic                    ack_o;

  // MIG user-interface side
  logic                    init_calib_complete;
  logic [APP_ADDR_W-1:0]   app_addr;
  logic [2:0]              app_cmd;
  logic                    app_en;
  logic                    app_rdy;
  logic [APP_DATA_W-1:0]   app_wdf_data;
  logic [APP_DATA_W/8-1:0] app_wdf_mask;
  logic                    app_wdf_wren;
  logic                    app_wdf_end;
  logic                    app_wdf_rdy;
  logic [APP_DATA_W-1:0]   app_rd_data;
  logic                    app_rd_data_valid;

  modport master (
    input  ram_ce_i, ram_we_i, ram_addr_i, ram_sel_i, ram_data_i,
    output ram_data_o, stall_o, ack_o,
    input  init_calib_complete,
    output app_addr, app_cmd, app_en,
    input  app_rdy,
    output app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    input  app_wdf_rdy, app_rd_data, app_rd_data_valid
  );

  modport slave (
    output ram_ce_i, ram_we_i, ram_addr_i, ram_sel_i, ram_data_i,
    input  ram_data_o, stall_o, ack_o,
    output init_calib_complete,
    input  app_addr, app_cmd, app_en,
    output app_rdy,
    input  app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    output app_wdf_rdy, app_rd_data, app_rd_data_valid
  );
endinterface
`default_nettype wire

// File: rtl/ddr_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : ddr_mem_bridge
// Description : Turns single 32-bit CPU data-RAM reads/writes (with byte
//               selects) into MIG DDR2 app_* commands on 128-bit bursts.
//               The CPU is stalled while a transaction is outstanding and
//               receives a one-cycle ack when it completes. Runs entirely
//               in the MIG user clock domain.
// Ports       : clk   - MIG user clock (ui_clk)
//               rst_n - asynchronous active-low reset
//               bus   - ddr_mem_bridge_if.master (CPU ram_* port, stall/ack,
//                       calibration status and MIG app_* interface)
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_mem_bridge #(
  parameter int APP_ADDR_W = 27,
  parameter int APP_DATA_W = 128   // fixed: four 32-bit lanes per burst
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  ddr_mem_bridge_if.master   bus
);

  localparam int MASK_W = APP_DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_RD_CMD  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [APP_ADDR_W-1:0] r_addr;
  logic [APP_DATA_W-1:0] r_wdata;
  logic [MASK_W-1:0]     r_mask;
  logic [1:0]            r_lane;
  logic                  r_cmd_done;   // write command accepted by MIG
  logic                  r_data_done;  // write data accepted by MIG
  logic [31:0]           r_rdata;
  logic                  w_capture;
  logic                  w_app_en;
  logic                  w_wren;
  logic                  w_unused;

  // Byte-address bits below the word and above the 256 MB window are don't-care.
  assign w_unused = ^{bus.ram_addr_i[31:28], bus.ram_addr_i[1:0]};

  // New requests are only taken in IDLE and only once the DDR is calibrated.
  assign w_capture = (r_state == S_IDLE) && bus.ram_ce_i && bus.init_calib_complete;

  always_comb begin
    w_next   = r_state;
    w_app_en = 1'b0;
    w_wren   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_capture) begin
          w_next = bus.ram_we_i ? S_WR : S_RD_CMD;
        end
      end
      S_WR: begin
        // Command and write data handshake independently; finish when both
        // have been accepted, whichever order (or cycle) they land in.
        w_app_en = !r_cmd_done;
        w_wren   = !r_data_done;
        if ((r_cmd_done || bus.app_rdy) && (r_data_done || bus.app_wdf_rdy)) begin
          w_next = S_DONE;
        end
      end
      S_RD_CMD: begin
        w_app_en = 1'b1;
        if (bus.app_rdy) begin
          w_next = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (bus.app_rd_data_valid) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_mask      <= '1;
      r_lane      <= 2'd0;
      r_cmd_done  <= 1'b0;
      r_data_done <= 1'b0;
      r_rdata     <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_capture) begin
        // Burst-aligned column address in x16 units (8 columns per 128 bits).
        r_addr      <= APP_ADDR_W'({bus.ram_addr_i[27:4], 3'b000});
        r_lane      <= bus.ram_addr_i[3:2];
        r_wdata     <= {4{bus.ram_data_i}};
        // Mask is active-high "do not write": only the selected bytes of the
        // addressed lane are cleared.
        r_mask      <= ~({12'b0, bus.ram_sel_i} << {bus.ram_addr_i[3:2], 2'b00});
        r_cmd_done  <= 1'b0;
        r_data_done <= 1'b0;
      end else if (r_state == S_WR) begin
        if (w_app_en && bus.app_rdy) begin
          r_cmd_done <= 1'b1;
        end
        if (w_wren && bus.app_wdf_rdy) begin
          r_data_done <= 1'b1;
        end
      end
      if ((r_state == S_RD_WAIT) && bus.app_rd_data_valid) begin
        r_rdata <= bus.app_rd_data[{r_lane, 5'b00000} +: 32];
      end
    end
  end

  assign bus.app_addr     = r_addr;
  assign bus.app_cmd      = (r_state == S_WR) ? 3'b000 : 3'b001;
  assign bus.app_en       = w_app_en;
  assign bus.app_wdf_data = r_wdata;
  assign bus.app_wdf_mask = r_mask;
  assign bus.app_wdf_wren = w_wren;
  assign bus.app_wdf_end  = w_wren;   // single-beat bursts: every beat is last
  assign bus.ram_data_o   = r_rdata;
  assign bus.ack_o        = (r_state == S_DONE);
  assign bus.stall_o      = (r_state == S_WR) || (r_state == S_RD_CMD) ||
                            (r_state == S_RD_WAIT) ||
                            ((r_state == S_IDLE) && bus.ram_ce_i);

endmodule
`default_nettype wire

// File: tb/tb_ddr_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr_mem_bridge
// Description : Self-checking bench for ddr_mem_bridge with a behavioural
//               MIG model (configurable ready delays and read latency).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_mem_bridge;

  localparam int AW = 27;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ddr_mem_bridge_if #(.APP_ADDR_W(AW), .APP_DATA_W(128)) bus();

  ddr_mem_bridge #(.APP_ADDR_W(AW), .APP_DATA_W(128)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- MIG model ----------------
  int           cfg_rdy_wait = 0;
  int           cfg_wdf_wait = 0;
  int           cfg_rd_lat   = 1;
  bit           model_kill   = 1'b0;
  bit           inj_valid    = 1'b0;
  logic [127:0] inj_data     = '0;
  logic [127:0] mem [logic [26:0]];
  logic [127:0] m_cur;
  logic [26:0]  m_rd_addr;
  int           m_rd_cnt  = 0;
  int           m_en_cnt  = 0;
  int           m_wdf_cnt = 0;

  initial begin
    bus.app_rdy           = 1'b0;
    bus.app_wdf_rdy       = 1'b0;
    bus.app_rd_data_valid = 1'b0;
    bus.app_rd_data       = '0;
    forever begin
      @(negedge clk);
      bus.app_rd_data_valid = 1'b0;
      if (model_kill) m_rd_cnt = 0;
      if (m_rd_cnt > 0) begin
        m_rd_cnt--;
        if (m_rd_cnt == 0) begin
          bus.app_rd_data_valid = 1'b1;
          bus.app_rd_data = mem.exists(m_rd_addr) ? mem[m_rd_addr] : '0;
        end
      end
      if (inj_valid) begin
        bus.app_rd_data_valid = 1'b1;
        bus.app_rd_data       = inj_data;
      end
      // command port
      if (bus.app_en) begin
        bus.app_rdy = (m_en_cnt >= cfg_rdy_wait);
        m_en_cnt++;
      end else begin
        bus.app_rdy = 1'b0;
        m_en_cnt    = 0;
      end
      if (bus.app_en && bus.app_rdy) begin
        if (bus.app_cmd == 3'b001) begin
          m_rd_addr = bus.app_addr;
          m_rd_cnt  = cfg_rd_lat;
        end else begin
          m_cur = mem.exists(bus.app_addr) ? mem[bus.app_addr] : '0;
          for (int b = 0; b < 16; b++)
            if (!bus.app_wdf_mask[b]) m_cur[8*b +: 8] = bus.app_wdf_data[8*b +: 8];
          mem[bus.app_addr] = m_cur;
        end
      end
      // write-data port
      if (bus.app_wdf_wren) begin
        bus.app_wdf_rdy = (m_wdf_cnt >= cfg_wdf_wait);
        m_wdf_cnt++;
      end else begin
        bus.app_wdf_rdy = 1'b0;
        m_wdf_cnt       = 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          we;
    logic [31:0] rdata;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
    int          rdy_wait;
    int          wdf_wait;
    int          rd_lat;
    int          calib_delay;
    logic [26:0] exp_addr;
    logic [15:0] exp_mask;
    logic [31:0] exp_rdata;
  } vec_t;

  function automatic vec_t mk(bit we, logic [31:0] a, logic [3:0] s, logic [31:0] d,
                              int rw, int dw, int lat, int cal,
                              logic [26:0] ea, logic [15:0] em, logic [31:0] er);
    vec_t v;
    v.we = we; v.addr = a; v.sel = s; v.data = d;
    v.rdy_wait = rw; v.wdf_wait = dw; v.rd_lat = lat; v.calib_delay = cal;
    v.exp_addr = ea; v.exp_mask = em; v.exp_rdata = er;
    return v;
  endfunction

  task automatic pop_check(input string name);
    exp_t p;
    if (sbq.size() == 0) begin
      check({name, " sb_empty"}, 1, 0);
    end else begin
      p = sbq.pop_front();
      check({name, " ram_data_o"}, bus.ram_data_o, p.rdata);
    end
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.ack_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_txn(input int idx, input vec_t v);
    int en_n, wr_n, lat, exp_lat;
    bit got_ack, stall_ok, gate_ok, end_ok, seen_en;
    logic first_en;
    logic [2:0]   cmd0;
    logic [26:0]  addr0;
    logic [15:0]  mask0;
    logic [127:0] wd0;
    exp_t e;
    cfg_rdy_wait = v.rdy_wait;
    cfg_wdf_wait = v.wdf_wait;
    cfg_rd_lat   = v.rd_lat;
    if (v.calib_delay > 0) bus.init_calib_complete = 1'b0;
    @(negedge clk);
    bus.ram_ce_i   = 1'b1;
    bus.ram_we_i   = v.we;
    bus.ram_addr_i = v.addr;
    bus.ram_sel_i  = v.sel;
    bus.ram_data_i = v.data;
    e.we = v.we; e.rdata = v.exp_rdata;
    sbq.push_back(e);
    if (v.calib_delay > 0) begin
      gate_ok = 1'b1;
      for (int i = 0; i < v.calib_delay; i++) begin
        @(negedge clk);
        if (bus.stall_o !== 1'b1 || bus.app_en !== 1'b0) gate_ok = 1'b0;
      end
      check($sformatf("v%0d calib_gate", idx), gate_ok, 1);
      bus.init_calib_complete = 1'b1;
    end
    en_n = 0; wr_n = 0; lat = 0; got_ack = 0; stall_ok = 1; end_ok = 1; seen_en = 0;
    first_en = 1'b0; cmd0 = '0; addr0 = '0; mask0 = '0; wd0 = '0;
    for (int c = 1; c <= 60 && !got_ack; c++) begin
      @(negedge clk);
      if (c == 1) begin
        first_en = bus.app_en;
        // captured copy must be used: scramble the CPU bus
        bus.ram_addr_i = $urandom;
        bus.ram_data_i = $urandom;
        bus.ram_sel_i  = 4'($urandom);
        bus.ram_we_i   = ~v.we;
      end
      if (bus.app_en) begin
        en_n++;
        if (!seen_en) begin
          seen_en = 1; cmd0 = bus.app_cmd; addr0 = bus.app_addr;
          mask0 = bus.app_wdf_mask; wd0 = bus.app_wdf_data;
        end
      end
      if (bus.app_wdf_wren) wr_n++;
      if (bus.app_wdf_end !== bus.app_wdf_wren) end_ok = 0;
      if (bus.ack_o) begin
        got_ack = 1; lat = c;
      end else if (bus.stall_o !== 1'b1) begin
        stall_ok = 0;
      end
    end
    exp_lat = v.we ? ((v.rdy_wait > v.wdf_wait ? v.rdy_wait : v.wdf_wait) + 2)
                   : (v.rdy_wait + v.rd_lat + 2);
    check($sformatf("v%0d ack_seen", idx), got_ack, 1);
    check($sformatf("v%0d start_next_cycle", idx), first_en, 1);
    check($sformatf("v%0d latency", idx), lat, exp_lat);
    check($sformatf("v%0d stall_busy", idx), stall_ok, 1);
    check($sformatf("v%0d stall_at_ack", idx), bus.stall_o, 0);
    check($sformatf("v%0d app_en_cycles", idx), en_n, v.rdy_wait + 1);
    check($sformatf("v%0d wren_cycles", idx), wr_n, v.we ? v.wdf_wait + 1 : 0);
    check($sformatf("v%0d wdf_end", idx), end_ok, 1);
    check($sformatf("v%0d app_cmd", idx), cmd0, v.we ? 3'b000 : 3'b001);
    check($sformatf("v%0d app_addr", idx), addr0, v.exp_addr);
    if (v.we) begin
      check($sformatf("v%0d wdf_mask", idx), mask0, v.exp_mask);
      check($sformatf("v%0d wdf_data", idx), wd0, {4{v.data}});
    end
    if (got_ack) pop_check($sformatf("v%0d", idx));
    else sbq.delete();
    bus.ram_ce_i = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d ack_one_cycle", idx), bus.ack_o, 0);
    check($sformatf("v%0d idle_stall", idx), bus.stall_o, 0);
  endtask

  vec_t vecs[17];

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok, no_ack;
    vecs[0]  = mk(1, 32'h0000_0014, 4'b0011, 32'h1234_5678, 0, 0, 1, 0,  27'h08, 16'hFFCF, 32'h0);
    vecs[1]  = mk(0, 32'h0000_0014, 4'b0000, 32'h0,         0, 0, 1, 0,  27'h08, 16'h0,    32'h0000_5678);
    vecs[2]  = mk(1, 32'h0000_001C, 4'b1111, 32'hCAFE_F00D, 0, 0, 1, 0,  27'h08, 16'h0FFF, 32'h0000_5678);
    vecs[3]  = mk(0, 32'h0000_0010, 4'b1111, 32'h0,         0, 0, 1, 0,  27'h08, 16'h0,    32'h0);
    vecs[4]  = mk(1, 32'h0000_0010, 4'b1000, 32'hAABB_CCDD, 0, 0, 1, 0,  27'h08, 16'hFFF7, 32'h0);
    vecs[5]  = mk(0, 32'h0000_0010, 4'b0000, 32'h0,         0, 0, 1, 0,  27'h08, 16'h0,    32'hAA00_0000);
    vecs[6]  = mk(0, 32'h0000_001C, 4'b0000, 32'h0,         0, 0, 5, 0,  27'h08, 16'h0,    32'hCAFE_F00D);
    vecs[7]  = mk(1, 32'hF000_0124, 4'b0100, 32'h1122_3344, 0, 0, 1, 0,  27'h90, 16'hFFBF, 32'hCAFE_F00D);
    vecs[8]  = mk(0, 32'h0000_0124, 4'b0000, 32'h0,         0, 0, 1, 0,  27'h90, 16'h0,    32'h0022_0000);
    vecs[9]  = mk(1, 32'h0000_0008, 4'b0000, 32'h5555_5555, 0, 0, 1, 0,  27'h00, 16'hFFFF, 32'h0022_0000);
    vecs[10] = mk(0, 32'h0000_0008, 4'b0000, 32'h0,         0, 0, 1, 0,  27'h00, 16'h0,    32'h0);
    vecs[11] = mk(1, 32'h0000_0020, 4'b1111, 32'h0102_0304, 0, 3, 1, 0,  27'h10, 16'hFFF0, 32'h0);
    vecs[12] = mk(1, 32'h0000_0024, 4'b0001, 32'h0000_00AB, 3, 0, 1, 0,  27'h10, 16'hFFEF, 32'h0);
    vecs[13] = mk(1, 32'h0000_0028, 4'b1100, 32'h9988_7766, 0, 0, 1, 10, 27'h10, 16'hF3FF, 32'h0);
    vecs[14] = mk(0, 32'h0000_0020, 4'b0000, 32'h0,         0, 0, 1, 0,  27'h10, 16'h0,    32'h0102_0304);
    vecs[15] = mk(0, 32'h0000_0024, 4'b0000, 32'h0,         2, 0, 3, 0,  27'h10, 16'h0,    32'h0000_00AB);
    vecs[16] = mk(0, 32'h0000_0028, 4'b0000, 32'h0,         0, 0, 1, 0,  27'h10, 16'h0,    32'h9988_0000);

    bus.ram_ce_i = 1'b0; bus.ram_we_i = 1'b0; bus.ram_addr_i = '0;
    bus.ram_sel_i = '0; bus.ram_data_i = '0; bus.init_calib_complete = 1'b1;

    // ---- reset values ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst app_en", bus.app_en, 0);
    check("rst app_wdf_wren", bus.app_wdf_wren, 0);
    check("rst app_cmd", bus.app_cmd, 3'b001);
    check("rst app_wdf_mask", bus.app_wdf_mask, 16'hFFFF);
    check("rst ack_stall", {bus.ack_o, bus.stall_o}, 2'b00);
    rst_n = 1'b1;

    // ---- reset in the middle of a read ----
    cfg_rdy_wait = 0; cfg_rd_lat = 20;
    @(negedge clk);
    bus.ram_ce_i = 1'b1; bus.ram_we_i = 1'b0; bus.ram_addr_i = 32'h0000_0030;
    repeat (3) @(negedge clk);
    check("mid_read in RD_WAIT", {bus.stall_o, bus.app_en}, 2'b10);
    rst_n = 1'b0;
    bus.ram_ce_i = 1'b0;
    #1;
    check("mid_rst app_en", bus.app_en, 0);
    check("mid_rst app_wdf_wren", bus.app_wdf_wren, 0);
    check("mid_rst app_wdf_end", bus.app_wdf_end, 0);
    check("mid_rst app_cmd", bus.app_cmd, 3'b001);
    check("mid_rst app_addr", bus.app_addr, 0);
    check("mid_rst app_wdf_data", bus.app_wdf_data, 0);
    check("mid_rst app_wdf_mask", bus.app_wdf_mask, 16'hFFFF);
    check("mid_rst ram_data_o", bus.ram_data_o, 0);
    check("mid_rst ack_stall", {bus.ack_o, bus.stall_o}, 2'b00);
    @(posedge clk); #1 model_kill = 1'b1;
    @(posedge clk); #1 model_kill = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1 inj_data = {4{32'hFFFF_FFFF}}; inj_valid = 1'b1;
    @(posedge clk); #1 inj_valid = 1'b0;
    no_ack = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (bus.ack_o) no_ack = 1'b0;
    end
    check("late_data no_ack", no_ack, 1);
    check("late_data ram_data_o", bus.ram_data_o, 0);
    check("late_data idle", {bus.stall_o, bus.app_en}, 2'b00);

    // ---- table-driven transactions ----
    for (int i = 0; i < 17; i++) do_txn(i, vecs[i]);

    // ---- back-to-back write then read, ram_ce_i held high ----
    cfg_rdy_wait = 0; cfg_wdf_wait = 0; cfg_rd_lat = 1;
    @(negedge clk);
    bus.ram_ce_i = 1'b1; bus.ram_we_i = 1'b1; bus.ram_addr_i = 32'h0000_0040;
    bus.ram_sel_i = 4'b1111; bus.ram_data_i = 32'hDEAD_BEEF;
    sbq.push_back('{we: 1'b1, rdata: 32'h9988_0000});
    wait_ack(ok);
    check("b2b wr ack", ok, 1);
    if (ok) pop_check("b2b wr");
    else sbq.delete();
    bus.ram_we_i = 1'b0;
    sbq.push_back('{we: 1'b0, rdata: 32'hDEAD_BEEF});
    @(negedge clk);
    check("b2b idle between", {bus.ack_o, bus.app_en, bus.stall_o}, 3'b001);
    wait_ack(ok);
    check("b2b rd ack", ok, 1);
    if (ok) pop_check("b2b rd");
    else sbq.delete();
    bus.ram_ce_i = 1'b0;
    @(negedge clk);
    check("b2b single ack", bus.ack_o, 0);
    check("b2b sb drained", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
